// File: rtl/iobuf_bus_pkg.sv
// Shared types for the half-duplex pad-bus sequencer: FSM states,
// bus direction and the width of the shared turnaround/latency counter.
package iobuf_bus_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    TURN,
    WR_SETUP,
    WR_STROBE,
    WR_HOLD,
    RD_STROBE,
    RD_CAP
  } state_t;

  typedef enum logic {
    DIR_RD = 1'b0,
    DIR_WR = 1'b1
  } dir_t;

endpackage

// File: rtl/iobuf_turn_timer.sv
// Loadable down-counter timing both the bus turnaround gap and the read
// strobe window. Loading value N makes done true on the Nth cycle after load.
module iobuf_turn_timer
  import iobuf_bus_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  output logic             done
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] count;

  // Count down to zero and park there until the next load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value - ONE;
    end else if (count != '0) begin
      count <= count - ONE;
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/iobuf_bus_sequencer.sv
// Sequences a shared tri-state data bus between a write and a read
// requester, inserting turnaround gaps on direction changes so the FPGA
// and the external device never drive the pads at the same time.
module iobuf_bus_sequencer
  import iobuf_bus_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int TURN_CYCLES = 1,
  parameter int RD_LATENCY  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_req,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ack,
  input  logic                  rd_req,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] pad_i,
  output logic                  pad_t,
  input  logic [DATA_WIDTH-1:0] pad_o,
  output logic                  ext_we_n,
  output logic                  ext_oe_n,
  output logic                  busy
);

  localparam logic [CNT_W-1:0] TURN_LOAD = CNT_W'(TURN_CYCLES);
  localparam logic [CNT_W-1:0] RD_LOAD   = CNT_W'(RD_LATENCY);

  state_t state, next_state;
  dir_t   last_dir, next_last_dir;
  dir_t   last_grant, next_last_grant;
  dir_t   pending_dir, next_pending_dir;
  dir_t   req_dir;

  logic             timer_load;
  logic [CNT_W-1:0] timer_value;
  logic             timer_done;

  iobuf_turn_timer u_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (timer_load),
    .load_value (timer_value),
    .done       (timer_done)
  );

  // FSM state plus the direction/arbitration history it depends on.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      last_dir    <= DIR_RD;
      last_grant  <= DIR_RD;
      pending_dir <= DIR_RD;
    end else begin
      state       <= next_state;
      last_dir    <= next_last_dir;
      last_grant  <= next_last_grant;
      pending_dir <= next_pending_dir;
    end
  end

  // Arbitration and next-state: grant is latched on leaving IDLE so TURN
  // completes the chosen transfer even if the requests move meanwhile.
  always_comb begin
    next_state       = state;
    next_last_dir    = last_dir;
    next_last_grant  = last_grant;
    next_pending_dir = pending_dir;
    req_dir          = DIR_RD;
    timer_load       = 1'b0;
    timer_value      = TURN_LOAD;

    case (state)
      IDLE: begin
        if (wr_req || rd_req) begin
          if (wr_req && rd_req) begin
            req_dir = (last_grant == DIR_RD) ? DIR_WR : DIR_RD;
          end else begin
            req_dir = wr_req ? DIR_WR : DIR_RD;
          end
          next_last_grant  = req_dir;
          next_pending_dir = req_dir;
          if (req_dir != last_dir) begin
            next_state  = TURN;
            timer_load  = 1'b1;
            timer_value = TURN_LOAD;
          end else if (req_dir == DIR_WR) begin
            next_state = WR_SETUP;
          end else begin
            next_state  = RD_STROBE;
            timer_load  = 1'b1;
            timer_value = RD_LOAD;
          end
        end
      end
      TURN: begin
        if (timer_done) begin
          next_last_dir = pending_dir;
          if (pending_dir == DIR_WR) begin
            next_state = WR_SETUP;
          end else begin
            next_state  = RD_STROBE;
            timer_load  = 1'b1;
            timer_value = RD_LOAD;
          end
        end
      end
      WR_SETUP:  next_state = WR_STROBE;
      WR_STROBE: next_state = WR_HOLD;
      WR_HOLD:   next_state = IDLE;
      RD_STROBE: begin
        if (timer_done) begin
          next_state = RD_CAP;
        end
      end
      RD_CAP:    next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  // Registered pad/strobe outputs decoded from the state being entered,
  // so every output lines up exactly with the state it belongs to.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pad_t    <= 1'b1;
      pad_i    <= '0;
      ext_we_n <= 1'b1;
      ext_oe_n <= 1'b1;
      wr_ack   <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      busy     <= 1'b0;
    end else begin
      pad_t    <= !(next_state inside {WR_SETUP, WR_STROBE, WR_HOLD});
      ext_we_n <= (next_state != WR_STROBE);
      ext_oe_n <= (next_state != RD_STROBE);
      wr_ack   <= (next_state == WR_HOLD);
      rd_valid <= (next_state == RD_CAP);
      busy     <= (next_state != IDLE);
      if (next_state == WR_SETUP) begin
        pad_i <= wr_data;
      end
      if (state == RD_STROBE && timer_done) begin
        rd_data <= pad_o;
      end
    end
  end

endmodule

// File: doc/iobuf_bus_sequencer.md
Name: iobuf_bus_sequencer

Overview:
- Sequences one shared half-duplex external data bus built from per-bit tri-state I/O buffers (I/T/O pins; T=1 releases pad to high-Z).
- Arbitrates a write requester and a read requester and drives buffer T/I plus external device strobes.
- Inserts turnaround cycles so the FPGA and the external device never drive simultaneously.
- Sits between the processor port logic and the pad-buffer array at the chip top level.

Parameters:
- DATA_WIDTH, 8: bus width; one I/O buffer per bit.
- TURN_CYCLES, 1: idle cycles on a direction change; legal 1..15.
- RD_LATENCY, 2: cycles ext_oe_n stays low before the pad is sampled; legal 1..15.

Ports:
- clk  input  1  single system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- wr_req  input  1  level; held until wr_ack.
- wr_data  input  DATA_WIDTH  held stable while wr_req=1.
- wr_ack  output  1  one-cycle pulse when the write completes.
- rd_req  input  1  level; held until rd_valid.
- rd_data  output  DATA_WIDTH  captured read data; holds until the next capture.
- rd_valid  output  1  one-cycle pulse when rd_data is updated.
- pad_i  output  DATA_WIDTH  to buffer I inputs.
- pad_t  output  1  to buffer T inputs (shared); 1=high-Z, 0=drive.
- pad_o  input  DATA_WIDTH  from buffer O outputs.
- ext_we_n  output  1  external write strobe, active-low.
- ext_oe_n  output  1  external output enable, active-low.
- busy  output  1  high in every state except IDLE.

Behaviour:
- All outputs registered. Reset values: pad_t=1, pad_i=0, ext_we_n=1, ext_oe_n=1, wr_ack=0, rd_valid=0, rd_data=0, busy=0, state=IDLE, last_dir=RD, last_grant=RD.
- Reset asserted mid-operation forces the reset values immediately (asynchronous), abandons the transfer, and generates no ack or valid.
- States: IDLE, TURN, WR_SETUP, WR_STROBE, WR_HOLD, RD_STROBE, RD_CAP.
- IDLE:
  - pad_t=1, strobes high.
  - Grant: if exactly one request is high, grant it. If both are high, grant the opposite of last_grant (round-robin).
  - If the granted direction != last_dir, go to TURN; otherwise go directly to WR_SETUP or RD_STROBE.
- TURN:
  - pad_t=1, both strobes high, for exactly TURN_CYCLES cycles (counted by sub-module).
  - Then go to the granted path and set last_dir to it.
  - The grant is latched on leaving IDLE. Requests dropping during TURN are protocol violations; the transfer still completes.
- WR_SETUP: pad_t=0, pad_i=wr_data, ext_we_n=1.
- WR_STROBE: pad_t=0, ext_we_n=0.
- WR_HOLD:
  - pad_t=0, ext_we_n=1, wr_ack=1 for this cycle.
  - Next state IDLE; pad_t returns to 1 there.
- Write latency with no turnaround: wr_ack is high 3 cycles after the IDLE grant cycle.
- RD_STROBE:
  - pad_t=1, ext_oe_n=0 for RD_LATENCY cycles.
  - On the last cycle, rd_data<=pad_o.
- RD_CAP:
  - ext_oe_n=1, rd_valid=1 for this cycle.
  - Next state IDLE.
- Read latency with no turnaround: rd_valid high RD_LATENCY+1 cycles after the grant cycle.
- Invariants:
  - pad_t=0 and ext_oe_n=0 are never true in the same cycle.
  - ext_we_n=0 only while pad_t=0.
- Back-to-back requests in the same direction take no TURN. Each transfer still passes through one IDLE cycle.
- A request still high in the IDLE cycle that follows its ack/valid is treated as a new request.

Decomposition:
- Package iobuf_bus_pkg holds:
  - state enum;
  - dir type (DIR_RD=0, DIR_WR=1);
  - 4-bit counter width constant.
- Sub-module iobuf_turn_timer:
  - loadable 4-bit down-counter with a done flag;
  - shared by TURN and RD_STROBE (loaded with TURN_CYCLES or RD_LATENCY).

Test Plan:
- Reset release then single write: wr_req=1, wr_data=8'hA5.
  - First write enters TURN for 1 cycle (last_dir=RD).
  - pad_t=0, pad_i=A5 for 3 cycles; ext_we_n low exactly 1 cycle (middle).
  - wr_ack pulses 4 cycles after the grant.
- Two writes back-to-back, 8'h11 then 8'h22:
  - no TURN between them;
  - wr_ack cycles 4 apart;
  - pad_t=1 only in the intervening IDLE cycle.
- Read after write, model drives pad_o=8'h3C while ext_oe_n=0:
  - TURN of 1 cycle with pad_t=1 and both strobes high;
  - ext_oe_n low 2 cycles;
  - rd_data=3C with rd_valid pulse.
- wr_req and rd_req raised together in the same cycle, held, after a read (last_grant=RD):
  - write is granted first, then read, then write;
  - grants alternate W,R,W,R over 4 transfers.
- TURN_CYCLES=3, RD_LATENCY=4:
  - direction change shows 3 turnaround cycles;
  - ext_oe_n low 4 cycles;
  - the assertion pad_t=0 and ext_oe_n=0 never fires.
- Reset pulsed during WR_STROBE:
  - pad_t=1 and ext_we_n=1 asynchronously;
  - no wr_ack;
  - the next write re-enters via TURN.
